mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port, byte-wide data RAM between two requesters: the CPU Memory stage (byte/halfword loads and stores) and the VGA pixel reader (byte reads).
- Sequences each halfword access as two atomic byte slots and stalls the pipeline while a CPU access is pending.
- Returns read data to each requester with fixed latency.
- Sits between the Memory stage / VGA scan logic and the RAM macro.

Parameters:
- ADDR_W, 19, byte address width for RAM and both requesters.
- VGA_STREAK, 4, maximum consecutive VGA grants while a CPU request waits; the CPU wins the next slot after that.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held stable until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- cpu_cant_byte  in  1  1 = one byte, 0 = two bytes (halfword)
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  16  store data; only [7:0] is used for a byte store
- cpu_rdata  out  19  load result, zero-extended
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  pipeline stall
- vga_req  in  1  VGA pixel read request; held until vga_gnt
- vga_addr  in  ADDR_W  pixel address
- vga_gnt  out  1  VGA slot granted this cycle
- vga_pixel  out  8  pixel data
- vga_valid  out  1  one-cycle pixel-valid pulse
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  8  RAM write byte
- ram_we  out  1  RAM write enable
- ram_rdata  in  8  RAM read data; valid one cycle after the address cycle

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high.
- Reset values: all outputs 0. The FSM goes to IDLE and the streak counter clears.
- Reset mid-operation: the in-flight transaction is abandoned with no done/valid pulse, and ram_we is 0 in the reset cycle.
- Slots: one RAM slot per cycle.
  - ram_addr, ram_we and ram_wdata are combinational from the current grant.
  - Ungranted cycles: ram_we=0, ram_addr=0.
- FSM states:
  - IDLE: no CPU transaction in flight.
  - CPU_HI: second byte slot of a halfword, forced to CPU, VGA blocked.
  - CPU_RET: CPU load data returning.
  - CPU_WB: registering done.
- Arbitration in IDLE when both request:
  - VGA wins, unless the streak counter equals VGA_STREAK; then CPU wins.
  - The counter increments on each VGA grant while cpu_req is pending.
  - The counter clears on any CPU grant, or when no CPU request is pending.
- No new CPU transaction starts until the current one signals cpu_done. cpu_req in the cycle cpu_done is high is ignored.
- A VGA slot may overlap the CPU_RET/CPU_WB cycles (pipelined).
- Byte load: granted slot N drives ram_addr=cpu_addr. Data is captured at the end of N+1; cpu_done and cpu_rdata={11'b0,byte} appear in N+2.
- Halfword load:
  - Slot N drives addr, slot N+1 drives addr+1 (CPU_HI); the two slots are back-to-back and atomic.
  - cpu_rdata={3'b0,hi,lo} with cpu_done in N+3.
  - Little-endian: lo is at addr.
- Byte store: slot N with ram_we=1, ram_wdata=cpu_wdata[7:0]; cpu_done in N+1.
- Halfword store: slot N writes cpu_wdata[7:0] to addr, slot N+1 writes cpu_wdata[15:8] to addr+1; cpu_done in N+2.
- Address wrap: addr+1 is computed modulo 2^ADDR_W, so a halfword at 0x7FFFF uses 0x7FFFF then 0x00000.
- VGA read: vga_gnt is high in slot N with ram_addr=vga_addr; vga_pixel and vga_valid appear in N+2. vga_pixel holds its value until the next valid.
- cpu_rdata holds its value until the next load completes; stores do not change it.
- cpu_stall = cpu_req & ~cpu_done (combinational).
- Idle cycles: with no requests, RAM outputs are 0 and no pulses occur.

Test Plan:
- Halfword store then read back: store 0xEEFF halfword at 0x6, then byte load 0x6 -> RAM[6]=0xFF, RAM[7]=0xEE; cpu_rdata=0x000FF; store done at N+2, load done 2 cycles after grant.
- Halfword load at 0x6 after byte store 0xAA to 0x7 -> cpu_rdata=0x0AAFF at N+3; cpu_stall high for 3 cycles.
- Continuous vga_req with a CPU byte load pending, VGA_STREAK=4 -> exactly 4 vga_gnt pulses, then a CPU slot, then VGA resumes; each vga_valid arrives 2 cycles after its vga_gnt.
- vga_req asserted during the second slot of a halfword store -> vga_gnt held off one cycle; both RAM bytes written correctly.
- Halfword store 0x1234 at 0x7FFFF -> RAM[0x7FFFF]=0x34, RAM[0x00000]=0x12.
- reset asserted in the CPU_HI cycle of a halfword store -> ram_we=0 that cycle, no cpu_done, FSM in IDLE, next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the byte-wide single-port data RAM between the CPU Memory stage and the VGA pixel reader.
// Latency: byte load done at N+2, halfword load N+3, byte store N+1, halfword store N+2; VGA pixel at N+2.
// Backpressure: CPU held by cpu_stall until cpu_done; VGA holds vga_req until vga_gnt (starvation-bounded).
module mem_port_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int VGA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_cant_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [18:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [7:0]        vga_pixel,
    output logic              vga_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    localparam int CNT_W = $clog2(VGA_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE,
        CPU_HI,
        CPU_RET,
        CPU_WB
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  streak;
    logic              streak_full;
    logic              cpu_gnt;

    // Transaction context latched at the CPU grant, used by the second slot and the return stage.
    logic              txn_we;
    logic              txn_byte;
    logic [ADDR_W-1:0] txn_addr_hi;
    logic [7:0]        txn_wdata_hi;
    logic [7:0]        lo_byte;
    logic              vga_rd_pend;

    assign streak_full = (streak == CNT_W'(VGA_STREAK));

    always_comb begin
        state_nxt = state;
        cpu_gnt   = 1'b0;
        vga_gnt   = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (!reset) begin
            case (state)
                IDLE: begin
                    cpu_gnt = cpu_req & (~vga_req | streak_full);
                    vga_gnt = vga_req & ~cpu_gnt;
                    if (cpu_gnt) begin
                        ram_addr  = cpu_addr;
                        ram_we    = cpu_we;
                        ram_wdata = cpu_we ? cpu_wdata[7:0] : 8'h00;
                        if (!cpu_cant_byte) begin
                            state_nxt = CPU_HI;
                        end else begin
                            state_nxt = cpu_we ? CPU_WB : CPU_RET;
                        end
                    end
                end
                CPU_HI: begin
                    // Second byte of a halfword owns the slot outright.
                    ram_addr  = txn_addr_hi;
                    ram_we    = txn_we;
                    ram_wdata = txn_we ? txn_wdata_hi : 8'h00;
                    state_nxt = txn_we ? CPU_WB : CPU_RET;
                end
                CPU_RET: begin
                    vga_gnt   = vga_req;
                    state_nxt = CPU_WB;
                end
                CPU_WB: begin
                    vga_gnt   = vga_req;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
            if (vga_gnt) begin
                ram_addr = vga_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Streak counts VGA wins only while the CPU is actually waiting in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (cpu_gnt || !cpu_req) begin
            streak <= '0;
        end else if (state == IDLE && vga_gnt && !streak_full) begin
            streak <= streak + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txn_we       <= 1'b0;
            txn_byte     <= 1'b0;
            txn_addr_hi  <= '0;
            txn_wdata_hi <= 8'h00;
        end else if (cpu_gnt) begin
            txn_we       <= cpu_we;
            txn_byte     <= cpu_cant_byte;
            txn_addr_hi  <= cpu_addr + ADDR_W'(1);
            txn_wdata_hi <= cpu_wdata[15:8];
        end
    end

    // The RAM returns the low byte while the high-byte address is being presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_byte   <= 8'h00;
            cpu_rdata <= '0;
        end else begin
            if (state == CPU_HI && !txn_we) begin
                lo_byte <= ram_rdata;
            end
            if (state == CPU_RET) begin
                cpu_rdata <= txn_byte ? 19'(ram_rdata) : 19'({ram_rdata, lo_byte});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rd_pend <= 1'b0;
            vga_valid   <= 1'b0;
            vga_pixel   <= 8'h00;
        end else begin
            vga_rd_pend <= vga_gnt;
            vga_valid   <= vga_rd_pend;
            if (vga_rd_pend) begin
                vga_pixel <= ram_rdata;
            end
        end
    end

    assign cpu_done  = ~reset & (state == CPU_WB);
    assign cpu_stall = ~reset & cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a behavioural byte RAM.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_cant_byte;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic [18:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_stall;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic [7:0]        vga_pixel;
    logic              vga_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .VGA_STREAK(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_cant_byte (cpu_cant_byte),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_done      (cpu_done),
        .cpu_stall     (cpu_stall),
        .vga_req       (vga_req),
        .vga_addr      (vga_addr),
        .vga_gnt       (vga_gnt),
        .vga_pixel     (vga_pixel),
        .vga_valid     (vga_valid),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_rdata     (ram_rdata)
    );

    // Synchronous byte RAM, read-before-write, unwritten locations read as zero.
    logic [7:0] mem [logic [ADDR_W-1:0]];
    always @(posedge clk) begin
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    typedef struct {
        logic              rst, creq, cwe, cbyte;
        logic [ADDR_W-1:0] caddr;
        logic [15:0]       cwd;
        logic              vreq;
        logic [ADDR_W-1:0] vaddr;
        logic              done, stall, gnt, valid, we;
        logic [ADDR_W-1:0] raddr;
        logic [7:0]        rwd;
        logic [18:0]       rdata;
        logic [7:0]        pix;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic creq, input logic cwe, input logic cbyte,
        input logic [ADDR_W-1:0] caddr, input logic [15:0] cwd,
        input logic vreq, input logic [ADDR_W-1:0] vaddr,
        input logic done, input logic stall, input logic gnt, input logic valid, input logic we,
        input logic [ADDR_W-1:0] raddr, input logic [7:0] rwd, input logic [18:0] rdata, input logic [7:0] pix);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.cbyte = cbyte; v.caddr = caddr; v.cwd = cwd;
        v.vreq = vreq; v.vaddr = vaddr; v.done = done; v.stall = stall; v.gnt = gnt; v.valid = valid;
        v.we = we; v.raddr = raddr; v.rwd = rwd; v.rdata = rdata; v.pix = pix;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        reset = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_cant_byte = v.cbyte;
        cpu_addr = v.caddr; cpu_wdata = v.cwd; vga_req = v.vreq; vga_addr = v.vaddr;
        @(negedge clk);
        chk({nm, " done/stall/gnt/valid/we"}, {cpu_done, cpu_stall, vga_gnt, vga_valid, ram_we},
            {v.done, v.stall, v.gnt, v.valid, v.we});
        chk({nm, " ram_addr"}, ram_addr, v.raddr);
        chk({nm, " ram_wdata"}, ram_wdata, v.rwd);
        chk({nm, " cpu_rdata"}, cpu_rdata, v.rdata);
        chk({nm, " vga_pixel"}, vga_pixel, v.pix);
    endtask

    vec_t vecs[29];
    vec_t rvecs[9];

    initial begin
        bit [0:9] exp_gnt;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_cant_byte = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; vga_req = 1'b0; vga_addr = '0;

        //               rst creq we byte addr      wdata    vreq vaddr | done stall gnt vld we raddr    rwd    rdata     pix
        vecs[0]  = mk(1, 1, 0, 0, 'h0,     'h0,     1, 'h0,   0, 0, 0, 0, 0, 'h0,     'h00, 'h0,     'h00);
        vecs[1]  = mk(0, 1, 1, 0, 'h6,     'hEEFF,  0, 'h0,   0, 1, 0, 0, 1, 'h6,     'hFF, 'h0,     'h00);
        vecs[2]  = mk(0, 1, 1, 0, 'h6,     'hEEFF,  0, 'h0,   0, 1, 0, 0, 1, 'h7,     'hEE, 'h0,     'h00);
        vecs[3]  = mk(0, 1, 1, 0, 'h6,     'hEEFF,  0, 'h0,   1, 0, 0, 0, 0, 'h0,     'h00, 'h0,     'h00);
        vecs[4]  = mk(0, 1, 0, 1, 'h6,     'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h6,     'h00, 'h0,     'h00);
        vecs[5]  = mk(0, 1, 0, 1, 'h6,     'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h0,     'h00, 'h0,     'h00);
        vecs[6]  = mk(0, 1, 0, 1, 'h6,     'h0,     0, 'h0,   1, 0, 0, 0, 0, 'h0,     'h00, 'h000FF, 'h00);
        vecs[7]  = mk(0, 1, 1, 1, 'h7,     'h00AA,  0, 'h0,   0, 1, 0, 0, 1, 'h7,     'hAA, 'h000FF, 'h00);
        vecs[8]  = mk(0, 1, 1, 1, 'h7,     'h00AA,  0, 'h0,   1, 0, 0, 0, 0, 'h0,     'h00, 'h000FF, 'h00);
        vecs[9]  = mk(0, 1, 0, 0, 'h6,     'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h6,     'h00, 'h000FF, 'h00);
        vecs[10] = mk(0, 1, 0, 0, 'h6,     'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h7,     'h00, 'h000FF, 'h00);
        vecs[11] = mk(0, 1, 0, 0, 'h6,     'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h0,     'h00, 'h000FF, 'h00);
        vecs[12] = mk(0, 1, 0, 0, 'h6,     'h0,     0, 'h0,   1, 0, 0, 0, 0, 'h0,     'h00, 'h0AAFF, 'h00);
        vecs[13] = mk(0, 0, 0, 0, 'h0,     'h0,     0, 'h0,   0, 0, 0, 0, 0, 'h0,     'h00, 'h0AAFF, 'h00);
        vecs[14] = mk(0, 1, 1, 0, 'h10,    'h5678,  0, 'h0,   0, 1, 0, 0, 1, 'h10,    'h78, 'h0AAFF, 'h00);
        vecs[15] = mk(0, 1, 1, 0, 'h10,    'h5678,  1, 'h10,  0, 1, 0, 0, 1, 'h11,    'h56, 'h0AAFF, 'h00);
        vecs[16] = mk(0, 1, 1, 0, 'h10,    'h5678,  1, 'h10,  1, 0, 1, 0, 0, 'h10,    'h00, 'h0AAFF, 'h00);
        vecs[17] = mk(0, 0, 0, 0, 'h0,     'h0,     1, 'h11,  0, 0, 1, 0, 0, 'h11,    'h00, 'h0AAFF, 'h00);
        vecs[18] = mk(0, 0, 0, 0, 'h0,     'h0,     0, 'h0,   0, 0, 0, 1, 0, 'h0,     'h00, 'h0AAFF, 'h78);
        vecs[19] = mk(0, 0, 0, 0, 'h0,     'h0,     0, 'h0,   0, 0, 0, 1, 0, 'h0,     'h00, 'h0AAFF, 'h56);
        vecs[20] = mk(0, 0, 0, 0, 'h0,     'h0,     0, 'h0,   0, 0, 0, 0, 0, 'h0,     'h00, 'h0AAFF, 'h56);
        vecs[21] = mk(0, 1, 1, 0, 'h7FFFF, 'h1234,  0, 'h0,   0, 1, 0, 0, 1, 'h7FFFF, 'h34, 'h0AAFF, 'h56);
        vecs[22] = mk(0, 1, 1, 0, 'h7FFFF, 'h1234,  0, 'h0,   0, 1, 0, 0, 1, 'h0,     'h12, 'h0AAFF, 'h56);
        vecs[23] = mk(0, 1, 1, 0, 'h7FFFF, 'h1234,  0, 'h0,   1, 0, 0, 0, 0, 'h0,     'h00, 'h0AAFF, 'h56);
        vecs[24] = mk(0, 1, 0, 0, 'h7FFFF, 'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h7FFFF, 'h00, 'h0AAFF, 'h56);
        vecs[25] = mk(0, 1, 0, 0, 'h7FFFF, 'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h0,     'h00, 'h0AAFF, 'h56);
        vecs[26] = mk(0, 1, 0, 0, 'h7FFFF, 'h0,     0, 'h0,   0, 1, 0, 0, 0, 'h0,     'h00, 'h0AAFF, 'h56);
        vecs[27] = mk(0, 1, 0, 0, 'h7FFFF, 'h0,     0, 'h0,   1, 0, 0, 0, 0, 'h0,     'h00, 'h01234, 'h56);
        vecs[28] = mk(0, 0, 0, 0, 'h0,     'h0,     0, 'h0,   0, 0, 0, 0, 0, 'h0,     'h00, 'h01234, 'h56);

        for (int i = 0; i < 29; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // VGA streak: CPU byte load at 0x10 waits behind four VGA wins, then VGA resumes.
        exp_gnt = 10'b1111011100;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0; cpu_req = (i < 7); cpu_we = 1'b0; cpu_cant_byte = 1'b1;
            cpu_addr = 'h10; cpu_wdata = '0; vga_req = (i < 8); vga_addr = 'h11;
            @(negedge clk);
            chk($sformatf("streak%0d vga_gnt", i), vga_gnt, exp_gnt[i]);
            chk($sformatf("streak%0d vga_valid", i), vga_valid, (i >= 2) ? exp_gnt[i-2] : 1'b0);
            chk($sformatf("streak%0d cpu_done", i), cpu_done, (i == 6));
            chk($sformatf("streak%0d ram_addr", i), ram_addr,
                exp_gnt[i] ? 19'h11 : ((i == 4) ? 19'h10 : 19'h0));
        end
        chk("streak cpu_rdata", cpu_rdata, 19'h00078);
        chk("streak vga_pixel", vga_pixel, 8'h56);

        // Reset lands on the high-byte slot of a halfword store at 0x30.
        rvecs[0] = mk(0, 1, 1, 0, 'h30, 'hBEEF, 0, 'h0,   0, 1, 0, 0, 1, 'h30, 'hEF, 'h00078, 'h56);
        rvecs[1] = mk(1, 1, 1, 0, 'h30, 'hBEEF, 0, 'h0,   0, 0, 0, 0, 0, 'h0,  'h00, 'h00078, 'h56);
        rvecs[2] = mk(0, 1, 0, 1, 'h30, 'h0,    0, 'h0,   0, 1, 0, 0, 0, 'h30, 'h00, 'h0,     'h00);
        rvecs[3] = mk(0, 1, 0, 1, 'h30, 'h0,    0, 'h0,   0, 1, 0, 0, 0, 'h0,  'h00, 'h0,     'h00);
        rvecs[4] = mk(0, 1, 0, 1, 'h30, 'h0,    0, 'h0,   1, 0, 0, 0, 0, 'h0,  'h00, 'h000EF, 'h00);
        rvecs[5] = mk(0, 1, 0, 1, 'h31, 'h0,    0, 'h0,   0, 1, 0, 0, 0, 'h31, 'h00, 'h000EF, 'h00);
        rvecs[6] = mk(0, 1, 0, 1, 'h31, 'h0,    0, 'h0,   0, 1, 0, 0, 0, 'h0,  'h00, 'h000EF, 'h00);
        rvecs[7] = mk(0, 1, 0, 1, 'h31, 'h0,    0, 'h0,   1, 0, 0, 0, 0, 'h0,  'h00, 'h0,     'h00);
        rvecs[8] = mk(0, 0, 0, 0, 'h0,  'h0,    0, 'h0,   0, 0, 0, 0, 0, 'h0,  'h00, 'h0,     'h00);
        for (int i = 0; i < 9; i++) begin
            run_vec(rvecs[i], $sformatf("rst%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
